rx_gasket_fifo: RTL and testbench
=================================

Name: rx_gasket_fifo

Overview:
Parametrised receive-side gasket between the symbol-rate recovered clock (clk_to_get) and the PIPE parallel clock (PCLK). It packs 8-bit symbols into 8/16/32/…-bit words and aligns word boundaries on COM K-symbols. SKP K-symbols are dropped. Completed words, with per-byte K flags, cross to PCLK through a gray-coded asynchronous FIFO. It sits between the 8b/10b decoder and the PIPE RX data interface.

Parameters:
MAX_BYTES, 4, maximum bytes per word; legal width values are 8*2^k ≤ 8*MAX_BYTES; power of 2.
FIFO_DEPTH, 8, async FIFO entries; power of 2, ≥4.
COM_SYM, 8'hBC, K-symbol that forces lane-0 alignment.
SKP_SYM, 8'h7C, K-symbol discarded before packing.

Ports:
clk_to_get  in  1  symbol clock; write side.
Rst_n  in  1  reset, asynchronous, active-low; resets both clock domains.
PCLK  in  1  parallel clock; read side.
sym_valid  in  1  Data_in/Rx_Datak qualify this clk_to_get cycle.
Data_in  in  8  decoded symbol.
Rx_Datak  in  1  Data_in is a K-symbol.
width  in  6  word width in bits: 8, 16, 32 (up to 8*MAX_BYTES); quasi-static.
Data_out  out  8*MAX_BYTES  packed word, LSB byte = first received; unused upper bytes zero.
Datak_out  out  MAX_BYTES  per-byte K flag, aligned with Data_out bytes.
Rx_valid  out  1  Data_out/Datak_out valid this PCLK cycle.
overflow  out  1  sticky (clk_to_get domain): a completed word was dropped because the FIFO was full.
width_err  out  1  clk_to_get domain: width value is illegal.

Behaviour:
- Reset: lane counter 0, partial word cleared, FIFO pointers 0, Data_out 0, Datak_out 0, Rx_valid 0, overflow 0, width_err 0. Rst_n assertion mid-word discards all data in both domains.
- N = width/8. width_err is registered, =1 while N is not a legal value. While width_err=1, no bytes are packed and the lane counter is held at 0.
- A symbol is accepted only when sym_valid=1.
- SKP: Rx_Datak=1 and Data_in=SKP_SYM → dropped. It does not advance the lane counter or enter the word.
- COM: Rx_Datak=1 and Data_in=COM_SYM → any partial word is discarded, and the COM is written to lane 0. Lane counter becomes 1, or the word completes immediately if N=1.
- Other accepted symbols go to lane[cnt], with their K bit in k[cnt]; cnt increments.
- When the byte filling lane N-1 is accepted, the word is complete. In the next clk_to_get cycle it is written to the FIFO and cnt is 0.
- A change of width while cnt≠0 discards the partial word; cnt returns to 0 on the next cycle.
- FIFO write when full: the word is dropped and overflow is set. overflow is cleared only by Rst_n. No existing entry is corrupted.
- FIFO pointers: binary plus gray, one extra wrap bit. Each gray pointer crosses via a 2-flop synchroniser.
- Full = write-gray equals synced-read-gray with the top 2 bits inverted.
- Empty = read-gray equals synced-write-gray.
- Read side pops one entry per PCLK cycle whenever not empty. Data_out/Datak_out/Rx_valid are registered.
- When empty, Rx_valid=0 and Data_out/Datak_out are 0.
- Latency: a word completed at clk_to_get edge t is written at t+1. It appears with Rx_valid=1 no more than 4 PCLK edges after the write (2 sync + empty compare + output register).
- Simultaneous COM and word-complete cannot collide: the COM always restarts. A word completing on the COM itself (N=1) is written normally.
- Word ordering is preserved. No duplication and no loss except on overflow, realignment, width change or reset.

Test Plan:
- Width 32, clocks equal freq, stream K BC, 01, 02, 03, 04, 05, 06, 07 → Data_out 0x030201BC with Datak_out 4'b0001, then 0x07060504 with 4'b0000; Rx_valid one cycle each.
- Width 16, stream 11, K 7C, 22, 33, 44 → SKP dropped; words 0x2211, 0x4433.
- Width 32, stream AA, BB, K BC, CC, DD, EE → the AA/BB partial word is discarded; the only output is 0xEEDDCCBC.
- Width 8, FIFO_DEPTH 8, PCLK held stopped, 10 symbols sent → first 8 stored, overflow=1. After PCLK starts, exactly 8 words are output in order; overflow stays 1 until Rst_n.
- width=24 → width_err=1 and no Rx_valid. Then width=8, symbols 5A, A5 → width_err=0, outputs 0x5A, 0xA5.
- Width 32, Rst_n pulsed after 2 bytes, PCLK 3× slower than clk_to_get → all outputs are 0. After reset, the next 4 bytes form the first word and no residue appears.

Source files
------------

// File: rtl/rx_gasket_fifo.sv
// Packs 8b symbols into COM-aligned words (SKP dropped) and crosses them to PCLK via a gray async FIFO.
// Latency: word written 1 clk_to_get after completion, visible within 4 PCLK edges; full FIFO drops words (sticky overflow).
module rx_gasket_fifo #(
   parameter int          MAX_BYTES  = 4,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [7:0]  COM_SYM    = 8'hBC,
   parameter logic [7:0]  SKP_SYM    = 8'h7C
) (
   input  logic                     clk_to_get,
   input  logic                     Rst_n,
   input  logic                     PCLK,
   input  logic                     sym_valid,
   input  logic [7:0]               Data_in,
   input  logic                     Rx_Datak,
   input  logic [5:0]               width,
   output logic [8*MAX_BYTES-1:0]   Data_out,
   output logic [MAX_BYTES-1:0]     Datak_out,
   output logic                     Rx_valid,
   output logic                     overflow,
   output logic                     width_err
);

   localparam int         AW   = $clog2(FIFO_DEPTH);
   localparam int         DW   = 8*MAX_BYTES;
   localparam int         EW   = 9*MAX_BYTES;
   localparam logic [5:0] MAXB = 6'(MAX_BYTES);

   function automatic logic width_legal(input logic [5:0] w);
      logic [5:0] n;
      n = {3'b000, w[5:3]};
      return (w[2:0] == 3'b000) && (n != 6'd0) && ((n & (n - 6'd1)) == 6'd0) && (n <= MAXB);
   endfunction

   // ---------------- write (symbol) domain ----------------
   logic [5:0]           width_q;
   logic [5:0]           cnt_q, cnt_d;
   logic [DW-1:0]        acc_q, acc_d;
   logic [MAX_BYTES-1:0] kacc_q, kacc_d;
   logic [DW-1:0]        word_d, pend_dat;
   logic [MAX_BYTES-1:0] wordk_d, pend_k;
   logic                 done, wr_pend;
   logic [5:0]           n_q, pos;
   logic                 is_com, is_skp, width_chg;

   assign n_q       = {3'b000, width_q[5:3]};
   assign is_com    = Rx_Datak && (Data_in == COM_SYM);
   assign is_skp    = Rx_Datak && (Data_in == SKP_SYM);
   assign width_chg = (width != width_q);

   always_comb begin
      acc_d   = acc_q;
      kacc_d  = kacc_q;
      cnt_d   = cnt_q;
      word_d  = '0;
      wordk_d = '0;
      done    = 1'b0;
      pos     = cnt_q;
      if (width_chg || width_err) begin
         acc_d  = '0;
         kacc_d = '0;
         cnt_d  = '0;
      end else if (sym_valid && !is_skp) begin
         // COM always restarts the word in lane 0, discarding any partial bytes
         if (is_com) begin
            acc_d  = '0;
            kacc_d = '0;
            pos    = '0;
         end
         for (int i = 0; i < MAX_BYTES; i++) begin
            if (pos == 6'(i)) begin
               acc_d[i*8 +: 8] = Data_in;
               kacc_d[i]       = Rx_Datak;
            end
         end
         if (pos == n_q - 6'd1) begin
            done    = 1'b1;
            word_d  = acc_d;
            wordk_d = kacc_d;
            acc_d   = '0;
            kacc_d  = '0;
            cnt_d   = '0;
         end else begin
            cnt_d = pos + 6'd1;
         end
      end
   end

   logic [EW-1:0]  mem [FIFO_DEPTH];
   logic [AW:0]    wbin, wgray, wbin_nx;
   logic [AW:0]    rgray, rq1, rq2;
   logic           full, do_wr;

   assign full    = (wgray == {~rq2[AW:AW-1], rq2[AW-2:0]});
   assign do_wr   = wr_pend && !full;
   assign wbin_nx = wbin + 1'b1;

   always_ff @(posedge clk_to_get or negedge Rst_n) begin
      if (!Rst_n) begin
         width_q   <= '0;
         width_err <= 1'b0;
         cnt_q     <= '0;
         acc_q     <= '0;
         kacc_q    <= '0;
         wr_pend   <= 1'b0;
         pend_dat  <= '0;
         pend_k    <= '0;
         wbin      <= '0;
         wgray     <= '0;
         rq1       <= '0;
         rq2       <= '0;
         overflow  <= 1'b0;
      end else begin
         width_q   <= width;
         width_err <= !width_legal(width);
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         kacc_q    <= kacc_d;
         wr_pend   <= done;
         pend_dat  <= word_d;
         pend_k    <= wordk_d;
         rq1       <= rgray;
         rq2       <= rq1;
         if (do_wr) begin
            wbin  <= wbin_nx;
            wgray <= (wbin_nx >> 1) ^ wbin_nx;
         end
         if (wr_pend && full)
            overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk_to_get) begin
      if (do_wr)
         mem[wbin[AW-1:0]] <= {pend_k, pend_dat};
   end

   // ---------------- read (PCLK) domain ----------------
   logic [AW:0] rbin, rbin_nx, wq1, wq2;
   logic        empty;

   assign empty   = (rgray == wq2);
   assign rbin_nx = rbin + 1'b1;

   always_ff @(posedge PCLK or negedge Rst_n) begin
      if (!Rst_n) begin
         rbin      <= '0;
         rgray     <= '0;
         wq1       <= '0;
         wq2       <= '0;
         Data_out  <= '0;
         Datak_out <= '0;
         Rx_valid  <= 1'b0;
      end else begin
         wq1 <= wgray;
         wq2 <= wq1;
         if (!empty) begin
            {Datak_out, Data_out} <= mem[rbin[AW-1:0]];
            Rx_valid              <= 1'b1;
            rbin                  <= rbin_nx;
            rgray                 <= (rbin_nx >> 1) ^ rbin_nx;
         end else begin
            Data_out  <= '0;
            Datak_out <= '0;
            Rx_valid  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rx_gasket_fifo.sv
// Directed bench for rx_gasket_fifo: packing, SKP/COM handling, overflow, width errors and reset.
module tb_rx_gasket_fifo;

   logic        clk_to_get = 1'b0;
   logic        PCLK       = 1'b0;
   logic        Rst_n      = 1'b0;
   logic        sym_valid  = 1'b0;
   logic [7:0]  Data_in    = '0;
   logic        Rx_Datak   = 1'b0;
   logic [5:0]  width      = 6'd32;
   logic [31:0] Data_out;
   logic [3:0]  Datak_out;
   logic        Rx_valid, overflow, width_err;

   int n_cmp = 0;
   int n_bad = 0;
   int pclk_half = 5;
   bit pclk_en   = 1'b1;
   logic [35:0] q[$];

   rx_gasket_fifo dut (
      .clk_to_get (clk_to_get),
      .Rst_n      (Rst_n),
      .PCLK       (PCLK),
      .sym_valid  (sym_valid),
      .Data_in    (Data_in),
      .Rx_Datak   (Rx_Datak),
      .width      (width),
      .Data_out   (Data_out),
      .Datak_out  (Datak_out),
      .Rx_valid   (Rx_valid),
      .overflow   (overflow),
      .width_err  (width_err)
   );

   initial forever #5 clk_to_get = ~clk_to_get;

   // Stoppable PCLK, always parks low
   initial begin
      #2;
      forever begin
         #(pclk_half);
         if (pclk_en || PCLK) PCLK = ~PCLK;
      end
   end

   always @(negedge PCLK) if (Rx_valid) q.push_back({Datak_out, Data_out});

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ent(input int i);
      if (i < q.size()) return 64'(q[i]);
      return '1;
   endfunction

   task automatic send(input logic k, input logic [7:0] d);
      @(negedge clk_to_get);
      sym_valid = 1'b1;
      Rx_Datak  = k;
      Data_in   = d;
      @(negedge clk_to_get);
      sym_valid = 1'b0;
      Rx_Datak  = 1'b0;
   endtask

   task automatic send_burst(input int cnt, input logic [7:0] first);
      @(negedge clk_to_get);
      for (int i = 0; i < cnt; i++) begin
         sym_valid = 1'b1;
         Rx_Datak  = 1'b0;
         Data_in   = first + 8'(i);
         @(negedge clk_to_get);
      end
      sym_valid = 1'b0;
   endtask

   task automatic set_width(input logic [5:0] w);
      @(negedge clk_to_get);
      width = w;
      repeat (3) @(negedge clk_to_get);
   endtask

   task automatic drain();
      repeat (60) @(negedge clk_to_get);
   endtask

   initial begin
      repeat (3) @(negedge clk_to_get);
      check("rst_data",  64'(Data_out),  64'h0);
      check("rst_k",     64'(Datak_out), 64'h0);
      check("rst_vld",   64'(Rx_valid),  64'h0);
      check("rst_ovf",   64'(overflow),  64'h0);
      check("rst_werr",  64'(width_err), 64'h0);
      Rst_n = 1'b1;
      repeat (2) @(negedge clk_to_get);

      // width 32, COM-aligned stream
      q.delete();
      send(1, 8'hBC);
      for (int i = 1; i < 8; i++) send(0, 8'(i));
      drain();
      check("w32_cnt",   64'(q.size()), 64'd2);
      check("w32_w0",    ent(0), 64'h1_030201BC);
      check("w32_w1",    ent(1), 64'h0_07060504);
      check("idle_data", 64'(Data_out), 64'h0);

      // width 16 with SKP in the middle
      set_width(6'd16);
      q.delete();
      send(0, 8'h11); send(1, 8'h7C); send(0, 8'h22); send(0, 8'h33); send(0, 8'h44);
      drain();
      check("w16_cnt",   64'(q.size()), 64'd2);
      check("w16_w0",    ent(0), 64'h0_00002211);
      check("w16_w1",    ent(1), 64'h0_00004433);

      // COM realignment discards partial word
      set_width(6'd32);
      q.delete();
      send(0, 8'hAA); send(0, 8'hBB); send(1, 8'hBC);
      send(0, 8'hCC); send(0, 8'hDD); send(0, 8'hEE);
      drain();
      check("realign_cnt", 64'(q.size()), 64'd1);
      check("realign_w0",  ent(0), 64'h1_EEDDCCBC);

      // overflow with PCLK stopped
      set_width(6'd8);
      q.delete();
      pclk_en = 1'b0;
      repeat (4) @(negedge clk_to_get);
      send_burst(10, 8'h00);
      repeat (6) @(negedge clk_to_get);
      check("ovf_set",    64'(overflow), 64'h1);
      check("ovf_noout",  64'(q.size()), 64'd0);
      pclk_en = 1'b1;
      drain();
      check("ovf_cnt",    64'(q.size()), 64'd8);
      for (int i = 0; i < 8; i++) check($sformatf("ovf_w%0d", i), ent(i), 64'(i));
      check("ovf_sticky", 64'(overflow), 64'h1);

      // illegal width, then recovery; reset also clears overflow
      @(negedge clk_to_get);
      Rst_n = 1'b0;
      repeat (2) @(negedge clk_to_get);
      check("rst2_ovf", 64'(overflow), 64'h0);
      Rst_n = 1'b1;
      q.delete();
      set_width(6'd24);
      check("werr_set", 64'(width_err), 64'h1);
      send(0, 8'h01); send(0, 8'h02); send(0, 8'h03);
      drain();
      check("werr_noout", 64'(q.size()), 64'd0);
      set_width(6'd8);
      check("werr_clr", 64'(width_err), 64'h0);
      send(0, 8'h5A); send(0, 8'hA5);
      drain();
      check("w8_cnt", 64'(q.size()), 64'd2);
      check("w8_w0",  ent(0), 64'h0_0000005A);
      check("w8_w1",  ent(1), 64'h0_000000A5);

      // reset mid-word with slow PCLK
      set_width(6'd32);
      pclk_half = 15;
      q.delete();
      send(0, 8'h31); send(0, 8'h32);
      @(negedge clk_to_get);
      Rst_n = 1'b0;
      repeat (2) @(negedge clk_to_get);
      check("mid_rst_data", 64'(Data_out), 64'h0);
      check("mid_rst_vld",  64'(Rx_valid), 64'h0);
      repeat (4) @(negedge clk_to_get);
      Rst_n = 1'b1;
      repeat (2) @(negedge clk_to_get);
      for (int i = 0; i < 4; i++) send(0, 8'h10 + 8'(i));
      repeat (150) @(negedge clk_to_get);
      check("post_rst_cnt", 64'(q.size()), 64'd1);
      check("post_rst_w0",  ent(0), 64'h0_13121110);
      check("post_rst_ovf", 64'(overflow), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
